mode1_max_stream: RTL and testbench
===================================

Name: mode1_max_stream

Overview:
- Streaming max-reduction engine for softmax mode 1.
- Consumes a vector of `DATAWIDTH floating-point elements, two per beat, over a valid/ready handshake, and tracks the running maximum.
- Presents the final maximum on a held output with valid/ready handshake. This is the value that feeds the b operand of the mode-2 subtract stage.
- Sits between the input buffer read port and the mode2 subtract lanes.

Parameters:
PAIR_CNT_W, 16, width of the pair-count input (max vector length = 2*(2^PAIR_CNT_W - 1) elements)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; latches num_pairs and begins a reduction
num_pairs  input  PAIR_CNT_W  number of input beats (element pairs) in the vector
in_valid  input  1  inp0/inp1 carry a valid pair
in_ready  output  1  block accepts a pair this cycle
inp0  input  `DATAWIDTH  element 2k
inp1  input  `DATAWIDTH  element 2k+1
max_out  output  `DATAWIDTH  reduction result
max_valid  output  1  max_out is final
max_ready  input  1  consumer accepts max_out
busy  output  1  high from the cycle after start until the result handshake completes

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, signal reset, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=0, max_valid=0, busy=0, max_out=0, internal pair counter=0.
- Reset mid-operation returns the block to IDLE on the next edge and discards any partial result.
- Number format: `DATAWIDTH = 1 + `EXPONENT + `MANTISSA, IEEE layout.
- Comparison is a strict "greater than" on IEEE order:
  - Positive > negative.
  - Positives ordered by magnitude; negatives ordered by inverse magnitude.
  - +0 and -0 are equal.
  - NaN inputs are out of scope; the result is undefined.
- Pair selection: pair_max = inp1 if inp1 > inp0, else inp0 (ties keep inp0).
- Running update: run_max <= pair_max if pair_max > run_max, else unchanged (ties keep the earlier value).
- State IDLE:
  - in_ready=0, busy=0.
  - On start with num_pairs!=0: latch count, load run_max with -infinity (sign=1, exponent all ones, mantissa 0), go to ACCUM.
  - On start with num_pairs==0: load run_max=-infinity, go to DONE.
- State ACCUM:
  - in_ready=1, busy=1.
  - A beat is accepted when in_valid && in_ready; it updates run_max and decrements the remaining count.
  - When the accepted beat is the last one (remaining==1), go to DONE; in_ready drops in the cycle after that beat.
  - Cycles with in_valid=0 are bubbles: no state change.
- State DONE:
  - max_valid=1, max_out=run_max, busy=1, in_ready=0.
  - max_out is held stable while max_valid && !max_ready.
  - On max_ready, return to IDLE; max_valid is 0 in the next cycle.
- Latency: max_valid rises exactly 1 cycle after the clock edge that accepts the last pair. For zero stalls, total cycles from start to max_valid = num_pairs + 1.
- start while busy=1 is ignored; num_pairs is not re-latched.
- start asserted in the same cycle as the DONE handshake is ignored. The block must sit in IDLE for at least one cycle before a new start is accepted.
- in_valid outside ACCUM is ignored, with no side effects.
- The arithmetic is combinational compare only; no rounding is involved. The result is always bit-exact to one of the inputs, or -infinity for an empty vector.
- The counter is PAIR_CNT_W bits and never wraps, because it is loaded once and counts down to zero.

Test Plan:
- Basic fp16 (`EXPONENT=5, `MANTISSA=10): start, num_pairs=3, pairs (0x3C00,0x4000),(0xC000,0x4200),(0x3800,0x0000) with no stalls -> max_out=0x4200 (3.0) with max_valid 4 cycles after start; in_ready high for exactly 3 cycles.
- All negative: num_pairs=2, pairs (0xC400,0xC200),(0xBC00,0xC500) -> max_out=0xBC00 (-1.0).
- Zero sign and ties: num_pairs=1, pair (0x8000,0x0000) -> max_out=0x8000 (tie keeps inp0). Then num_pairs=2, pairs (0x4000,0x3C00),(0x3C00,0x4000) -> max_out=0x4000 with no spurious update.
- Handshake stalls: in_valid toggled randomly over num_pairs=5; max_ready held low for 4 cycles -> max_out stable while held, max_valid deasserts the cycle after max_ready=1, busy low afterwards; result matches the reference model.
- Empty and ignored start: start with num_pairs=0 -> max_out=0xFC00 (-infinity), max_valid the next cycle. A second start pulsed during ACCUM of a num_pairs=4 run -> ignored, exactly 4 beats consumed.
- Reset mid-run: assert reset after 2 of 4 pairs -> next cycle in_ready=0, max_valid=0, busy=0. A fresh start with num_pairs=1, pair (0x4800,0x4400) -> max_out=0x4800, no residue from the aborted run.

Source files
------------

// File: rtl/mode1_max_stream.sv
// ---------------------------------------------------------------------------
// mode1_max_stream
//
// Streaming max-reduction engine for softmax mode 1. A vector of IEEE-layout
// floating-point elements arrives two per beat over a valid/ready handshake.
// The block keeps a running maximum and presents the final value on a held
// valid/ready output. That value feeds the b operand of the mode-2 subtract
// stage.
//
// Ports
//   clk        : clock
//   reset      : synchronous active-high reset
//   start      : one-cycle pulse; latches num_pairs and begins a reduction
//                (ignored unless the block is idle)
//   num_pairs  : number of element pairs (beats) in the vector; 0 = empty
//   in_valid   : inp0/inp1 carry a valid pair
//   in_ready   : block accepts a pair this cycle (registered)
//   inp0       : element 2k
//   inp1       : element 2k+1
//   max_out    : reduction result, held while max_valid && !max_ready
//   max_valid  : max_out is final (registered)
//   max_ready  : consumer accepts max_out
//   busy       : high from the cycle after start until the result handshake
// ---------------------------------------------------------------------------
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef DATAWIDTH
`define DATAWIDTH (1 + `EXPONENT + `MANTISSA)
`endif

module mode1_max_stream #(
  parameter int PAIR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PAIR_CNT_W-1:0] num_pairs,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`DATAWIDTH-1:0] inp0,
  input  logic [`DATAWIDTH-1:0] inp1,
  output logic [`DATAWIDTH-1:0] max_out,
  output logic                  max_valid,
  input  logic                  max_ready,
  output logic                  busy
);

  localparam int W   = `DATAWIDTH;
  localparam int EXP = `EXPONENT;
  localparam int MAN = `MANTISSA;

  // -infinity: sign set, exponent all ones, mantissa zero. Every finite or
  // infinite non-NaN value compares >= this, so it is the neutral start value.
  localparam logic [W-1:0] NEG_INF = {1'b1, {EXP{1'b1}}, {MAN{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Strict "a > b" in IEEE order for non-NaN operands. Signed zeros are
  // treated as equal; otherwise sign decides, then magnitude (inverted for
  // negatives). The magnitude field compares correctly as an unsigned integer
  // because exponent sits above mantissa.
  function automatic logic fp_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic          a_zero;
    logic          b_zero;
    logic [W-2:0]  a_mag;
    logic [W-2:0]  b_mag;
    logic          gt;
    a_mag  = a[W-2:0];
    b_mag  = b[W-2:0];
    a_zero = (a_mag == '0);
    b_zero = (b_mag == '0);
    if (a_zero && b_zero) begin
      gt = 1'b0;
    end else if (!a[W-1] && b[W-1]) begin
      gt = 1'b1;
    end else if (a[W-1] && !b[W-1]) begin
      gt = 1'b0;
    end else if (!a[W-1]) begin
      gt = (a_mag > b_mag);
    end else begin
      gt = (a_mag < b_mag);
    end
    return gt;
  endfunction

  // State and registered outputs
  state_t                state_q,     state_d;
  logic [PAIR_CNT_W-1:0] remaining_q, remaining_d;
  logic [W-1:0]          run_max_q,   run_max_d;
  logic [W-1:0]          max_out_q,   max_out_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  max_valid_q, max_valid_d;
  logic                  busy_q,      busy_d;

  // Datapath: pair reduction then running update. Ties keep the earlier
  // operand in both stages (inp0 within a pair, the old run_max across beats).
  logic [W-1:0] pair_max;
  logic [W-1:0] run_upd;
  logic         accept;

  always_comb begin
    pair_max = fp_gt(inp1, inp0) ? inp1 : inp0;
    run_upd  = fp_gt(pair_max, run_max_q) ? pair_max : run_max_q;
  end

  // in_ready_q is only ever high in ACCUM, so this also gates off in_valid
  // outside the accumulation phase.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    run_max_d   = run_max_q;
    max_out_d   = max_out_q;
    in_ready_d  = in_ready_q;
    max_valid_d = max_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        in_ready_d  = 1'b0;
        max_valid_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          run_max_d = NEG_INF;
          busy_d    = 1'b1;
          if (num_pairs != '0) begin
            remaining_d = num_pairs;
            in_ready_d  = 1'b1;
            state_d     = ACCUM;
          end else begin
            // Empty vector: the result is -infinity, available next cycle.
            remaining_d = '0;
            max_out_d   = NEG_INF;
            max_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          run_max_d   = run_upd;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == PAIR_CNT_W'(1)) begin
            // Last beat: publish the updated maximum directly so max_valid
            // rises on the very next cycle.
            max_out_d   = run_upd;
            max_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        // max_out_q is not touched here, so it holds while the consumer stalls.
        // start is deliberately not looked at in this state.
        if (max_ready) begin
          max_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b0;
        max_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      run_max_q   <= '0;
      max_out_q   <= '0;
      in_ready_q  <= 1'b0;
      max_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      run_max_q   <= run_max_d;
      max_out_q   <= max_out_d;
      in_ready_q  <= in_ready_d;
      max_valid_q <= max_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign max_valid = max_valid_q;
  assign max_out   = max_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mode1_max_stream.sv
// Directed testbench for mode1_max_stream (fp16 layout).
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef DATAWIDTH
`define DATAWIDTH (1 + `EXPONENT + `MANTISSA)
`endif

module tb_mode1_max_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_pairs;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inp0;
  logic [15:0] inp1;
  logic [15:0] max_out;
  logic        max_valid;
  logic        max_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mode1_max_stream #(.PAIR_CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_pairs (num_pairs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp0      (inp0),
    .inp1      (inp1),
    .max_out   (max_out),
    .max_valid (max_valid),
    .max_ready (max_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
    $display("check %s observed %h expected %h", tag, obs, exp_v);
  endtask

  // Advance one clock edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until accepted (bounded).
  task automatic feed(input logic [15:0] a, input logic [15:0] b);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    inp0     = a;
    inp1     = b;
    for (int t = 0; t < 20; t++) begin
      acc = in_ready;
      step();
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("feed_accepted", {15'd0, acc}, 16'd1);
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 20; t++) begin
      if (max_valid) break;
      step();
    end
    chk("wait_max_valid", {15'd0, max_valid}, 16'd1);
  endtask

  task automatic do_start(input logic [15:0] n);
    start     = 1'b1;
    num_pairs = n;
    step();
    start     = 1'b0;
  endtask

  task automatic handshake();
    max_ready = 1'b1;
    step();
    max_ready = 1'b0;
    chk("hs_valid_low", {15'd0, max_valid}, 16'd0);
    chk("hs_busy_low",  {15'd0, busy},      16'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_pairs = '0; in_valid = 1'b0;
    inp0 = '0; inp1 = '0; max_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready",  {15'd0, in_ready},  16'd0);
    chk("rst_max_valid", {15'd0, max_valid}, 16'd0);
    chk("rst_busy",      {15'd0, busy},      16'd0);
    chk("rst_max_out",   max_out,            16'h0000);
    step();

    // Basic: 3 pairs, no stalls -> 3.0, valid 4 cycles after the start cycle
    do_start(16'd3);
    chk("t1_ready_b0", {15'd0, in_ready}, 16'd1);
    chk("t1_busy",     {15'd0, busy},     16'd1);
    feed(16'h3C00, 16'h4000);
    chk("t1_ready_b1", {15'd0, in_ready}, 16'd1);
    feed(16'hC000, 16'h4200);
    chk("t1_ready_b2", {15'd0, in_ready}, 16'd1);
    chk("t1_not_done", {15'd0, max_valid}, 16'd0);
    feed(16'h3800, 16'h0000);
    chk("t1_ready_drop", {15'd0, in_ready},  16'd0);
    chk("t1_valid",      {15'd0, max_valid}, 16'd1);
    chk("t1_max",        max_out,            16'h4200);
    handshake();
    step();

    // All negative -> -1.0
    do_start(16'd2);
    feed(16'hC400, 16'hC200);
    feed(16'hBC00, 16'hC500);
    wait_valid();
    chk("t2_max", max_out, 16'hBC00);
    handshake();
    step();

    // Signed zero tie keeps inp0
    do_start(16'd1);
    feed(16'h8000, 16'h0000);
    wait_valid();
    chk("t3_zero_tie", max_out, 16'h8000);
    handshake();
    step();

    // Equal values across beats
    do_start(16'd2);
    feed(16'h4000, 16'h3C00);
    feed(16'h3C00, 16'h4000);
    wait_valid();
    chk("t3_equal", max_out, 16'h4000);
    handshake();
    step();

    // Bubbles on input, stalled consumer -> 5.0
    do_start(16'd5);
    step();
    feed(16'h3C00, 16'hBC00);
    step(); step();
    feed(16'h4400, 16'h4200);
    feed(16'hC800, 16'h4500);
    step();
    chk("t4_busy_mid", {15'd0, busy}, 16'd1);
    feed(16'h0000, 16'h8000);
    step(); step(); step();
    chk("t4_not_done", {15'd0, max_valid}, 16'd0);
    feed(16'h4480, 16'h3000);
    wait_valid();
    for (int k = 0; k < 4; k++) begin
      chk("t4_hold_max",   max_out,            16'h4500);
      chk("t4_hold_valid", {15'd0, max_valid}, 16'd1);
      step();
    end
    chk("t4_max_after_hold", max_out, 16'h4500);
    handshake();
    step();

    // Empty vector -> -infinity the next cycle
    do_start(16'd0);
    chk("t5_empty_valid", {15'd0, max_valid}, 16'd1);
    chk("t5_empty_max",   max_out,            16'hFC00);
    chk("t5_empty_ready", {15'd0, in_ready},  16'd0);
    chk("t5_empty_busy",  {15'd0, busy},      16'd1);
    handshake();
    step();

    // Start pulsed during ACCUM is ignored: exactly 4 beats consumed
    do_start(16'd4);
    feed(16'h3C00, 16'h3800);
    feed(16'h4000, 16'h3400);
    start = 1'b1; num_pairs = 16'd1;
    step();
    start = 1'b0;
    feed(16'h4200, 16'h4400);
    chk("t5_ign_ready", {15'd0, in_ready},  16'd1);
    chk("t5_ign_valid", {15'd0, max_valid}, 16'd0);
    feed(16'h4600, 16'h4100);
    chk("t5_ign_done",  {15'd0, max_valid}, 16'd1);
    chk("t5_ign_max",   max_out,            16'h4600);
    chk("t5_ign_ready_low", {15'd0, in_ready}, 16'd0);
    // start coinciding with the result handshake is ignored
    start = 1'b1; num_pairs = 16'd1;
    handshake();
    start = 1'b0;
    chk("t5_hs_start_ready", {15'd0, in_ready}, 16'd0);
    step();
    chk("t5_hs_start_busy", {15'd0, busy}, 16'd0);

    // Reset mid-run, in_valid while idle, then a clean run
    do_start(16'd4);
    feed(16'h5000, 16'h4C00);
    feed(16'h3C00, 16'h3800);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_ready", {15'd0, in_ready},  16'd0);
    chk("t6_rst_valid", {15'd0, max_valid}, 16'd0);
    chk("t6_rst_busy",  {15'd0, busy},      16'd0);
    in_valid = 1'b1; inp0 = 16'h7000; inp1 = 16'h7000;
    step();
    in_valid = 1'b0;
    chk("t6_idle_ready", {15'd0, in_ready}, 16'd0);
    chk("t6_idle_busy",  {15'd0, busy},     16'd0);
    do_start(16'd1);
    feed(16'h4800, 16'h4400);
    wait_valid();
    chk("t6_fresh_max", max_out, 16'h4800);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
